// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and default geometry for the PC sequencer.
package pc_seq_pkg;
    localparam int ADDR_W_DEF    = 8;
    localparam int STEP_DEF      = 4;
    localparam int RAS_DEPTH_DEF = 4;
    typedef enum logic [1:0] {RESET_HOLD, RUN, FLUSH, HALTED} pc_state_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push onto a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         overflow
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, ptr_m1, wr_idx;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full, pop_eff, ovf_q, ovf_d;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (PW+1)'(DEPTH);
        pop_eff = pop && !empty;
        ptr_m1  = ptr_q - 1'b1;
        top     = mem_q[ptr_m1];
        // pop-then-push rewrites the popped slot in place
        wr_idx  = pop_eff ? ptr_m1 : ptr_q;
        ptr_d   = reset ? '0 : push ? wr_idx + 1'b1 : wr_idx;
        cnt_d   = reset ? '0 : (push && !pop_eff && !full) ? cnt_q + 1'b1 :
                  (pop_eff && !push) ? cnt_q - 1'b1 : cnt_q;
        ovf_d   = !reset && push && !pop_eff && full;
    end
    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        if (push && !reset) mem_q[wr_idx] <= push_data;
    end
    assign overflow = ovf_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: advances, holds or redirects the PC and flushes IF/ID on taken branches.
// Define PC_SEQ_RAS_EN to build the call/return address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int STEP      = STEP_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              branch_link,
    input  logic              branch_return,
    input  logic              halt,
    input  logic              resume,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] pc_next,
    output logic              flush,
    output logic              halted,
    output logic              ras_overflow
);
    pc_state_e         state_q, state_d;
    logic              halted_q, halted_d;
    logic              active, take;
    logic [ADDR_W-1:0] inc, target;
    assign inc = pc_current + ADDR_W'(STEP);
`ifdef PC_SEQ_RAS_EN
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    pc_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (take && branch_link),
        .pop       (take && branch_return),
        .push_data (inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );
    assign target = (branch_return && !ras_empty) ? ras_top : branch_target;
`else
    logic unused_ras;
    assign unused_ras   = branch_link ^ branch_return ^ (RAS_DEPTH > 0);
    assign target       = branch_target;
    assign ras_overflow = 1'b0;
`endif
    always_comb begin
        active    = (state_q == RUN) || (state_q == FLUSH);
        // a taken branch overrides stall, so the redirect is never lost
        take      = !reset && active && !halt && branch_valid;
        pc_enable = !reset && active && !halt && (branch_valid || !stall);
        pc_next   = reset ? '0 : take ? target : inc;
        flush     = !reset && (take || state_q == FLUSH);
        state_d   = reset ? RESET_HOLD :
                    (state_q == RESET_HOLD) ? RUN :
                    (state_q == HALTED) ? ((resume && !halt) ? RUN : HALTED) :
                    halt ? HALTED : branch_valid ? FLUSH : RUN;
        halted_d  = state_d == HALTED;
    end
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        halted_q <= halted_d;
    end
    assign halted = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus checked against a behavioural sequencer model.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset, stall, branch_valid, branch_link, branch_return, halt, resume;
    logic [7:0] pc_current, branch_target, pc_next;
    logic       pc_enable, flush, halted, ras_overflow;
    int         n_chk = 0, n_pass = 0;
    bit         m_hold, m_halt, m_fp, m_ovf;
    logic [7:0] ras[$];
    logic [7:0] ret_exp [5] = '{8'h14, 8'h10, 8'h0C, 8'h08, 8'hAA};

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_current    (pc_current),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .branch_link   (branch_link),
        .branch_return (branch_return),
        .halt          (halt),
        .resume        (resume),
        .pc_enable     (pc_enable),
        .pc_next       (pc_next),
        .flush         (flush),
        .halted        (halted),
        .ras_overflow  (ras_overflow)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
    endtask

    // apply inputs, let them settle mid-cycle, compare against the model
    task automatic drive(input logic r, st, bv, lk, rt, h, rs, input logic [7:0] pc, tg);
        logic       e_en, e_fl;
        logic [7:0] e_nx;
        bit         run;
        reset = r; stall = st; branch_valid = bv; branch_link = lk; branch_return = rt;
        halt = h; resume = rs; pc_current = pc; branch_target = tg;
        #4;
        run  = !r && !m_hold && !m_halt;
        e_nx = r ? 8'h00 : pc + 8'd4;
        e_en = 1'b0;
        e_fl = 1'b0;
        if (run) begin
            e_fl = m_fp;
            if (!h && bv) begin
                e_en = 1'b1;
                e_fl = 1'b1;
                e_nx = tg;
`ifdef PC_SEQ_RAS_EN
                if (rt && ras.size() > 0) e_nx = ras[$];
`endif
            end else if (!h && !st) e_en = 1'b1;
        end
        chkb("pc_enable", pc_enable, e_en);
        chk("pc_next", pc_next, e_nx);
        chkb("flush", flush, e_fl);
        chkb("halted", halted, m_halt);
        chkb("ras_overflow", ras_overflow, m_ovf);
    endtask

    // advance the model over the coming edge, then move to just after it
    task automatic adv();
        m_ovf = 1'b0;
        if (reset) begin
            m_hold = 1'b1; m_halt = 1'b0; m_fp = 1'b0;
            ras.delete();
        end else if (m_hold) m_hold = 1'b0;
        else if (m_halt) begin
            if (resume && !halt) m_halt = 1'b0;
        end else begin
            m_fp   = !halt && branch_valid;
            m_halt = halt;
`ifdef PC_SEQ_RAS_EN
            if (!halt && branch_valid) begin
                if (branch_return && ras.size() > 0) void'(ras.pop_back());
                if (branch_link) begin
                    ras.push_back(pc_current + 8'd4);
                    if (ras.size() > 4) begin
                        void'(ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_link = 1'b0;
        branch_return = 1'b0; halt = 1'b0; resume = 1'b0;
        pc_current = 8'h00; branch_target = 8'h00;
        m_hold = 1'b1; m_halt = 1'b0; m_fp = 1'b0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        chkb("rst_en", pc_enable, 1'b0); chkb("rst_flush", flush, 1'b0); chk("rst_next", pc_next, 8'h00);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        chkb("rel1_en", pc_enable, 1'b0);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        chkb("rel2_en", pc_enable, 1'b1); chk("rel2_next", pc_next, 8'h04);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'hFC, 8'h00);
        chk("wrap_next", pc_next, 8'h00);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h00);
            chkb("stall_en", pc_enable, 1'b0);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00);
        chkb("unstall_en", pc_enable, 1'b1); chk("unstall_next", pc_next, 8'h14);
        adv();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 8'h20, 8'h40);
            chkb("br_stall_en", pc_enable, 1'b1); chk("br_stall_next", pc_next, 8'h40);
            chkb("br_stall_flush", flush, 1'b1);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 8'h40, 8'h00);
        chkb("flush_tail", flush, 1'b1);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h44, 8'h00);
        chkb("flush_done", flush, 1'b0);
        adv();
        drive(0, 0, 0, 0, 0, 1, 0, 8'h48, 8'h00);
        chkb("halt_en", pc_enable, 1'b0);
        adv();
        drive(0, 0, 0, 0, 0, 1, 1, 8'h48, 8'h00);
        chkb("halt_both", halted, 1'b1);
        adv();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h48, 8'h80);
        chkb("halt_br_en", pc_enable, 1'b0); chkb("halt_br_halted", halted, 1'b1);
        adv();
        drive(0, 0, 0, 0, 0, 0, 1, 8'h48, 8'h00);
        chkb("resume_halted", halted, 1'b1);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h48, 8'h00);
        chkb("resumed_halted", halted, 1'b0); chkb("resumed_en", pc_enable, 1'b1);
        adv();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h50, 8'h60);
        adv();
        drive(1, 0, 0, 0, 0, 0, 0, 8'h60, 8'h00);
        chkb("rst_in_flush", flush, 1'b0);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h60, 8'h00);
        chkb("hold_en", pc_enable, 1'b0);
        adv();
`ifdef PC_SEQ_RAS_EN
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, 8'(i * 4), 8'h80);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 8'h80, 8'h00);
        chkb("ras_ovf_pulse", ras_overflow, 1'b1);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 1, 0, 0, 8'h90, 8'hAA);
            chk("ras_ret", pc_next, ret_exp[i]);
            adv();
        end
`endif
        repeat (400) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom));
            adv();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
